adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 16-bit adder datapath between NUM_REQ requesters.
- Accepts at most one operand pair per cycle over per-requester valid/ready handshakes.
- Pushes each accepted pair, with a requester tag, down a fixed-latency add pipeline.
- Routes each result back to its originator as a one-cycle response pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand and sum width.
- LAT, 2, adder pipeline depth in cycles, from handshake to response (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- arb_en  in  1  grant enable; 0 blocks new grants while in-flight ops drain.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing.
- resp_valid  out  NUM_REQ  one-hot one-cycle result pulse to the originating requester.
- resp_sum  out  DATA_W  shared result bus, meaningful when any resp_valid is high.
- resp_carry  out  1  carry-out of the add, qualified like resp_sum.
- grant_count  out  NUM_REQ*16  per-requester accepted-op counters (see Optional Feature).

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high.
  - Clears all pipeline valid bits.
  - Sets the round-robin pointer last_grant to NUM_REQ-1, so requester 0 has top priority first.
  - resp_valid=0, resp_sum=0, resp_carry=0, grant_count=0.
  - req_ready=0 while rst is high.
- Arbitration (combinational from req_valid, arb_en, last_grant):
  - Search starts at last_grant+1 mod NUM_REQ and ascends with wrap.
  - The first requester with req_valid=1 gets req_ready=1.
  - With no valid requester or arb_en=0, req_ready is all zero.
- Handshake:
  - Transfer happens when req_valid[i] & req_ready[i] at a rising edge.
  - On transfer: last_grant<=i; stage 0 captures req_a[i], req_b[i], tag=i and valid=1.
  - Without a transfer: stage 0 valid<=0 and last_grant holds.
  - Requesters must hold valid and operands stable until accepted. The arbiter never drops a pending valid.
- Pipeline:
  - LAT stages, no backpressure; one accept per cycle gives throughput of 1 op/cycle.
  - The add is {carry,sum} = a + b, DATA_W+1 bits wide; sum wraps mod 2^DATA_W.
  - Op accepted at edge T: resp_valid[tag] high for exactly the cycle after edge T+LAT-1, i.e. LAT cycles after acceptance.
  - resp_sum and resp_carry hold their last value when no response is valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 grants.
- Simultaneous events:
  - A requester may be accepted in the same cycle it receives a response.
  - Toggling arb_en mid-stream does not affect in-flight ops.
- Reset mid-operation: in-flight ops are discarded and no response pulses emerge after rst. Requesters must re-issue.
- Unused tag encodings (NUM_REQ not a power of two) never occur.

Optional Feature:
- Macro ADDER_ARB_STATS_EN.
- Defined:
  - grant_count slice i is a 16-bit counter, incremented on each transfer from requester i.
  - Saturates at 16'hFFFF (no wrap); cleared by rst.
- Undefined: grant_count is tied to 0 and no counter flops are built. The port stays present so the interface is stable.

Decomposition:
- Package adder_arb_pkg:
  - ADDER_W=16 and MAX_REQ=8 constants.
  - Tag width function clog2(NUM_REQ), floor 1.
  - Pipeline stage struct typedef {valid, tag, a, b}.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant and encoded index.
  - Reused by other shared-resource schedulers.

Test Plan:
- Reset, then req_valid=4'b0001 with a=16'h0003, b=16'h0004 → req_ready=4'b0001 the same cycle; 2 cycles later resp_valid=4'b0001, resp_sum=16'h0007, resp_carry=0.
- Wrap: a=16'hFFFF, b=16'h0002 from requester 2 → resp_sum=16'h0001, resp_carry=1, resp_valid=4'b0100.
- All four valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order at 1/cycle, each sum matching its tag's operands.
- arb_en=0 with two ops in flight → no new req_ready; both in-flight responses still appear. arb_en=1 then resumes at last_grant+1.
- rst asserted one cycle after accepting an op → no resp_valid pulse for that op; after rst, requester 0 has priority.
- With ADDER_ARB_STATS_EN: requester 1 accepted 5 times → grant_count[31:16]=5. Preload near max → saturates at 16'hFFFF. Without the macro, grant_count reads 0 throughout.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Stage records are sized for the widest supported configuration
// (ADDER_W data, tag for MAX_REQ requesters); narrower builds zero-extend.
package adder_arb_pkg;

  localparam int ADDER_W = 16;
  localparam int MAX_REQ = 8;

  // Requester tag width: clog2(n), never less than one bit.
  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_MAX_W = tag_w(MAX_REQ);

  // One slot of the add pipeline.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [ADDER_W-1:0]   a;
    logic [ADDER_W-1:0]   b;
  } stage_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: starting one past the previous winner,
// scans upward with wrap and grants the first active request.
// Reusable by any shared-resource scheduler.
module rr_pick #(
  parameter int N  = 4,
  parameter int TW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [TW-1:0] idx
);

  // Scan from last+1 mod N; the first hit wins and later hits are ignored.
  always_comb begin : p_pick
    logic [TW-1:0] j;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int off = 1; off <= N; off++) begin
      j = TW'((int'(last) + off) % N);
      if (req[j] && (gnt == '0)) begin
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one LAT-deep pipelined adder among NUM_REQ
// requesters. Each accepted operand pair travels with its requester tag and
// returns as a one-cycle resp_valid pulse on that requester's bit.
// Optional per-requester saturating grant counters: define ADDER_ARB_STATS_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int LAT     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_sum,
  output logic                      resp_carry,
  output logic [NUM_REQ*16-1:0]     grant_count
);

  localparam int TAG_W = tag_w(NUM_REQ);

  logic [TAG_W-1:0]   last_grant;
  logic [TAG_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [DATA_W:0]    tail_sum;
  stage_t             acc;
  stage_t             tail;

  // Grants are suppressed while disabled or in reset; in-flight ops are unaffected.
  assign pick_req  = req_valid & {NUM_REQ{arb_en & ~rst}};
  assign req_ready = pick_gnt;

  rr_pick #(
    .N  (NUM_REQ),
    .TW (TAG_W)
  ) u_pick (
    .req  (pick_req),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // Assemble the op being accepted this cycle (valid only on a transfer).
  always_comb begin
    acc       = '0;
    acc.valid = |pick_gnt;
    acc.tag   = TAG_MAX_W'(pick_idx);
    acc.a     = ADDER_W'(req_a[int'(pick_idx)*DATA_W +: DATA_W]);
    acc.b     = ADDER_W'(req_b[int'(pick_idx)*DATA_W +: DATA_W]);
  end

  // Round-robin pointer: reset makes requester 0 the first in line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      last_grant <= TAG_W'(NUM_REQ - 1);
    end else if (acc.valid) begin
      last_grant <= pick_idx;
    end
  end

  // LAT-1 operand stages; the response register is the final stage.
  if (LAT == 1) begin : g_direct
    assign tail = acc;
  end else begin : g_pipe
    stage_t stg [LAT-1];

    // Shift accepted ops toward the response register, no backpressure.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: only valid bits are reset; payload is never observed while its valid is low.
        for (int i = 0; i < LAT - 1; i++) stg[i].valid <= 1'b0;
      end else begin
        stg[0] <= acc;
        for (int i = 1; i < LAT - 1; i++) stg[i] <= stg[i-1];
      end
    end

    assign tail = stg[LAT-2];
  end

  assign tail_sum = {1'b0, tail.a[DATA_W-1:0]} + {1'b0, tail.b[DATA_W-1:0]};

  // Response stage: one-hot pulse to the originator; sum/carry hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
    end else begin
      resp_valid <= tail.valid ? (NUM_REQ'(1) << tail.tag) : '0;
      if (tail.valid) begin
        {resp_carry, resp_sum} <= tail_sum;
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  // Per-requester accepted-op counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick_gnt[i] && (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gc
    assign grant_count[i*16 +: 16] = cnt[i];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (NUM_REQ=4, DATA_W=16, LAT=2):
// single-op vector table, rotation fairness, arb_en drain, mid-op reset,
// and grant counters (build-dependent on ADDER_ARB_STATS_EN).
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int LAT     = 2;

  logic                      clk;
  logic                      rst;
  logic                      arb_en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_sum;
  logic                      resp_carry;
  logic [NUM_REQ*16-1:0]     grant_count;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .LAT     (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_sum    (resp_sum),
    .resp_carry  (resp_carry),
    .grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        carry;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b);
    req_a[r*DATA_W +: DATA_W] = a;
    req_b[r*DATA_W +: DATA_W] = b;
  endtask

  // Watchdog: no sequence below should come near this.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] fa [4];
    logic [15:0] fsum [4];
    logic        fcar [4];

    vecs[0] = '{0, 16'h0003, 16'h0004, 16'h0007, 1'b0};
    vecs[1] = '{2, 16'hFFFF, 16'h0002, 16'h0001, 1'b1};
    vecs[2] = '{1, 16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[3] = '{0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
    vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[5] = '{3, 16'h8000, 16'h8000, 16'h0000, 1'b1};

    fa[0] = 16'h0011; fsum[0] = 16'h0112; fcar[0] = 1'b0;  // + 0101
    fa[1] = 16'h4022; fsum[1] = 16'h5022; fcar[1] = 1'b0;  // + 1000
    fa[2] = 16'h8033; fsum[2] = 16'h0033; fcar[2] = 1'b1;  // + 8000
    fa[3] = 16'hF044; fsum[3] = 16'h1044; fcar[3] = 1'b1;  // + 2000

    // ---------------- reset ----------------
    rst       = 1'b1;
    arb_en    = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    step();
    step();
    check("ready_in_reset", 64'(req_ready), 64'h0);
    check("resp_valid_reset", 64'(resp_valid), 64'h0);
    check("resp_sum_reset", 64'(resp_sum), 64'h0);
    check("resp_carry_reset", 64'(resp_carry), 64'h0);
    check("grant_count_reset", grant_count, 64'h0);
    req_valid = '0;
    rst       = 1'b0;
    step();

    // ---------------- single-op vector table ----------------
    for (int v = 0; v < 6; v++) begin
      set_op(vecs[v].r, vecs[v].a, vecs[v].b);
      req_valid = NUM_REQ'(1) << vecs[v].r;
      #1;
      check($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(NUM_REQ'(1) << vecs[v].r));
      step();                       // accept edge
      req_valid = '0;
      check($sformatf("vec%0d_no_early_resp", v), 64'(resp_valid), 64'h0);
      step();                       // LAT cycles after acceptance
      check($sformatf("vec%0d_resp_valid", v), 64'(resp_valid), 64'(NUM_REQ'(1) << vecs[v].r));
      check($sformatf("vec%0d_sum", v), 64'(resp_sum), 64'(vecs[v].sum));
      check($sformatf("vec%0d_carry", v), 64'(resp_carry), 64'(vecs[v].carry));
      step();
      check($sformatf("vec%0d_pulse_end", v), 64'(resp_valid), 64'h0);
      check($sformatf("vec%0d_sum_hold", v), 64'(resp_sum), 64'(vecs[v].sum));
    end

    // ---------------- fairness: all valid for 8 grants ----------------
    for (int i = 0; i < 4; i++) set_op(i, fa[i], 16'h0101);
    set_op(1, fa[1], 16'h1000);
    set_op(2, fa[2], 16'h8000);
    set_op(3, fa[3], 16'h2000);
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        check($sformatf("rr%0d_resp_valid", c - 2), 64'(resp_valid), 64'(NUM_REQ'(1) << ((c - 2) % 4)));
        check($sformatf("rr%0d_sum", c - 2), 64'(resp_sum), 64'(fsum[(c - 2) % 4]));
        check($sformatf("rr%0d_carry", c - 2), 64'(resp_carry), 64'(fcar[(c - 2) % 4]));
      end
      req_valid = (c < 8) ? '1 : '0;
      #1;
      check($sformatf("rr_cycle%0d_ready", c), 64'(req_ready),
            (c < 8) ? 64'(NUM_REQ'(1) << (c % 4)) : 64'h0);
      step();
    end
`ifndef ADDER_ARB_STATS_EN
    check("grant_count_off_after_rr", grant_count, 64'h0);
`endif

    // ---------------- arb_en drain ----------------
    set_op(1, 16'h0005, 16'h0006);
    set_op(2, 16'h0007, 16'h0008);
    req_valid = 4'b0110;
    #1;
    check("en_first_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0100;
    #1;
    check("en_second_ready", 64'(req_ready), 64'h4);
    step();
    arb_en    = 1'b0;
    req_valid = 4'b1011;
    #1;
    check("en_off_ready0", 64'(req_ready), 64'h0);
    check("drain_resp1_valid", 64'(resp_valid), 64'h2);
    check("drain_resp1_sum", 64'(resp_sum), 64'h000B);
    step();
    check("en_off_ready1", 64'(req_ready), 64'h0);
    check("drain_resp2_valid", 64'(resp_valid), 64'h4);
    check("drain_resp2_sum", 64'(resp_sum), 64'h000F);
    step();
    check("en_off_ready2", 64'(req_ready), 64'h0);
    check("drain_idle", 64'(resp_valid), 64'h0);
    arb_en = 1'b1;
    #1;
    check("en_resume_ready", 64'(req_ready), 64'h8);
    req_valid = '0;
    step();
    step();
    step();

    // ---------------- reset mid-operation ----------------
    set_op(0, 16'h0001, 16'h0001);
    req_valid = 4'b0001;
    #1;
    check("rst_op_ready", 64'(req_ready), 64'h1);
    step();                         // accepted; last_grant becomes 0
    req_valid = '0;
    rst       = 1'b1;
    step();
    check("rst_kill_resp0", 64'(resp_valid), 64'h0);
    rst = 1'b0;
    step();
    check("rst_kill_resp1", 64'(resp_valid), 64'h0);
    check("rst_sum_cleared", 64'(resp_sum), 64'h0);
    step();
    check("rst_kill_resp2", 64'(resp_valid), 64'h0);
    req_valid = '1;
    #1;
    check("rst_priority_req0", 64'(req_ready), 64'h1);
    req_valid = '0;
    #1;

    // ---------------- grant counters ----------------
`ifdef ADDER_ARB_STATS_EN
    check("gc_after_rst", grant_count, 64'h0);
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) step();
    req_valid = '0;
    #1;
    check("gc_req1_five", 64'(grant_count[31:16]), 64'h5);
    check("gc_req0_zero", 64'(grant_count[15:0]), 64'h0);
    req_valid = 4'b0001;
    for (int k = 0; k < 65540; k++) step();
    req_valid = '0;
    step();
    check("gc_req0_saturate", 64'(grant_count[15:0]), 64'hFFFF);
    check("gc_req1_hold", 64'(grant_count[31:16]), 64'h5);
`else
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) step();
    req_valid = '0;
    step();
    check("grant_count_off_end", grant_count, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
